// File: rtl/datamem_pkg.sv
// Shared encodings for the data memory: access sizes, FSM states and legal read-latency range.
package datamem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  // Byte-lane write enables for a store of the given size at the given lane offset.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: lane_be = 4'b0001 << lane;
      SZ_HALF: lane_be = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/datamem_array.sv
// Word array with per-byte write enables and a registered read port.
// Latency: write lands on the enabling edge; read data valid the cycle after re.
// Backpressure: none, the caller sequences accesses.
module datamem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/datamem_bus.sv
// Byte-addressed load/store front end: alignment/range check, lane steering, load extension.
// Latency: store/error response 1 cycle after accept, load response RD_LAT cycles after accept.
// Backpressure: req_ready low while an access is in flight; the response cannot be stalled.
module datamem_bus
  import datamem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int LAT   = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((LAT >= 2) ? LAT - 2 : 0);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              acc;
  logic              req_err;
  logic [ADDR_W-1:0] addr_hi;

  logic              we_q, err_q, uns_q;
  logic [1:0]        size_q, lane_q;

  logic              arr_we, arr_re;
  logic [3:0]        arr_be;
  logic [31:0]       arr_wdata, arr_rdata;
  logic [31:0]       lane_dat, load_dat;

  assign acc     = req_valid & req_ready;
  // Any bit above the word-index field means the address lies past the array.
  assign addr_hi = req_addr >> (IDX_W + 2);

  always_comb begin
    req_err = (addr_hi != '0);
    case (req_size)
      SZ_BYTE: ;
      SZ_HALF: if (req_addr[0]) req_err = 1'b1;
      SZ_WORD: if (req_addr[1:0] != 2'b00) req_err = 1'b1;
      default: req_err = 1'b1;
    endcase
  end

  // FSM state register; rst drops any in-flight read so no response follows.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == RD_WAIT) ? cnt + 2'd1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc) state_nxt = (req_we || req_err || LAT == 1) ? RESP : RD_WAIT;
      RD_WAIT: if (cnt == LAST_CNT) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    case (state)
      IDLE: req_ready = ~rst;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (we_q || err_q) ? '0 : load_dat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      err_q  <= 1'b0;
      uns_q  <= 1'b0;
      size_q <= SZ_WORD;
      lane_q <= 2'b00;
    end else if (acc) begin
      we_q   <= req_we;
      err_q  <= req_err;
      uns_q  <= req_unsigned;
      size_q <= req_size;
      lane_q <= req_addr[1:0];
    end
  end

  assign arr_we = acc & req_we & ~req_err;
  assign arr_re = acc & ~req_we & ~req_err;
  assign arr_be = lane_be(req_size, req_addr[1:0]);

  // Replicate the right-aligned store data across lanes; byte enables pick the target.
  always_comb begin
    case (req_size)
      SZ_BYTE: arr_wdata = {4{req_wdata[7:0]}};
      SZ_HALF: arr_wdata = {2{req_wdata[15:0]}};
      default: arr_wdata = req_wdata;
    endcase
  end

  datamem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .be   (arr_be),
    .re   (arr_re),
    .idx  (req_addr[IDX_W+1:2]),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  always_comb begin
    lane_dat = arr_rdata >> {lane_q, 3'b000};
    case (size_q)
      SZ_BYTE: load_dat = {{24{~uns_q & lane_dat[7]}}, lane_dat[7:0]};
      SZ_HALF: load_dat = {{16{~uns_q & lane_dat[15]}}, lane_dat[15:0]};
      default: load_dat = arr_rdata;
    endcase
  end

endmodule

// File: tb/tb_datamem_bus.sv
// Directed bench: vector table on an RD_LAT=1 instance, hand sequences on an RD_LAT=3 instance.
module tb_datamem_bus;

  localparam int DEPTH = 256;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = 2'b00;

  logic        a_ready, a_rsp_valid, a_rsp_err;
  logic        b_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] a_rsp_rdata, b_rsp_rdata;
  logic        ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign ready     = sel ? b_ready     : a_ready;
  assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

  datamem_bus #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(a_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  datamem_bus #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(b_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  typedef struct {
    string       nm;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string nm, input logic we, input logic [31:0] addr,
                              input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                              input logic [31:0] exp_d, input logic exp_e);
    vec_t v;
    v.nm = nm; v.we = we; v.addr = addr; v.sz = sz; v.uns = uns;
    v.wd = wd; v.exp_d = exp_d; v.exp_e = exp_e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd);
    req_we = we; req_addr = addr; req_size = sz; req_unsigned = uns; req_wdata = wd;
  endtask

  // Called and returns #1 after a rising edge with the selected DUT idle.
  task automatic access(input vec_t v, input int lat);
    int n;
    drive(v.we, v.addr, v.sz, v.uns, v.wd);
    req_valid = 1'b1;
    n = 0;
    while (!ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check({v.nm, "_ready_timeout"}, 32'(n), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({v.nm, "_lat"}, 32'(n), 32'(lat));
    check({v.nm, "_rdata"}, rsp_rdata, v.exp_d);
    check({v.nm, "_err"}, 32'(rsp_err), 32'(v.exp_e));
    @(posedge clk); #1;
  endtask

  logic [7:0]  ref_b [0:4*DEPTH-1];
  logic        op_we   [4];
  logic [31:0] op_addr [4];
  logic [31:0] op_wd   [4];
  logic [31:0] exp_q[$];

  initial begin
    int idx, pulses, cyc;
    logic acc_now;
    logic [31:0] e;

    tbl.push_back(mk("sw_10",      1, 32'h10,       W, 0, 32'hDEADBEEF, 32'h0,        0));
    tbl.push_back(mk("lw_10",      0, 32'h10,       W, 0, 32'h0,        32'hDEADBEEF, 0));
    tbl.push_back(mk("sb_13",      1, 32'h13,       B, 0, 32'h5A5A5A80, 32'h0,        0));
    tbl.push_back(mk("lb_13",      0, 32'h13,       B, 0, 32'h0,        32'hFFFFFF80, 0));
    tbl.push_back(mk("lbu_13",     0, 32'h13,       B, 1, 32'h0,        32'h00000080, 0));
    tbl.push_back(mk("lw_10b",     0, 32'h10,       W, 0, 32'h0,        32'h80ADBEEF, 0));
    tbl.push_back(mk("sh_11_err",  1, 32'h11,       H, 0, 32'hFFFFFFFF, 32'h0,        1));
    tbl.push_back(mk("lw_12_err",  0, 32'h12,       W, 0, 32'h0,        32'h0,        1));
    tbl.push_back(mk("sz11_ld",    0, 32'h10,       X, 0, 32'h0,        32'h0,        1));
    tbl.push_back(mk("sz11_st",    1, 32'h10,       X, 0, 32'hFFFFFFFF, 32'h0,        1));
    tbl.push_back(mk("lw_oor",     0, 32'h400,      W, 0, 32'h0,        32'h0,        1));
    tbl.push_back(mk("sw_0",       1, 32'h0,        W, 0, 32'h0,        32'h0,        0));
    tbl.push_back(mk("sw_oor",     1, 32'h400,      W, 0, 32'h12345678, 32'h0,        1));
    tbl.push_back(mk("sw_hi",      1, 32'h80000010, W, 0, 32'hFFFFFFFF, 32'h0,        1));
    tbl.push_back(mk("lw_0",       0, 32'h0,        W, 0, 32'h0,        32'h0,        0));
    tbl.push_back(mk("lw_10c",     0, 32'h10,       W, 0, 32'h0,        32'h80ADBEEF, 0));
    tbl.push_back(mk("sw_14",      1, 32'h14,       W, 0, 32'h11223344, 32'h0,        0));
    tbl.push_back(mk("sh_16",      1, 32'h16,       H, 0, 32'h9999A55A, 32'h0,        0));
    tbl.push_back(mk("lw_14_u",    0, 32'h14,       W, 1, 32'h0,        32'hA55A3344, 0));
    tbl.push_back(mk("lh_16",      0, 32'h16,       H, 0, 32'h0,        32'hFFFFA55A, 0));
    tbl.push_back(mk("lhu_16",     0, 32'h16,       H, 1, 32'h0,        32'h0000A55A, 0));
    tbl.push_back(mk("lh_14",      0, 32'h14,       H, 0, 32'h0,        32'h00003344, 0));
    tbl.push_back(mk("lb_15",      0, 32'h15,       B, 0, 32'h0,        32'h00000033, 0));
    tbl.push_back(mk("lbu_17",     0, 32'h17,       B, 1, 32'h0,        32'h000000A5, 0));
    tbl.push_back(mk("sw_top",     1, 32'h3FC,      W, 0, 32'hCAFEBABE, 32'h0,        0));
    tbl.push_back(mk("lw_top",     0, 32'h3FC,      W, 0, 32'h0,        32'hCAFEBABE, 0));
    tbl.push_back(mk("lh_top",     0, 32'h3FE,      H, 0, 32'h0,        32'hFFFFCAFE, 0));

    // Reset held for three edges, then released.
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_ready",  32'(a_ready),     32'd0);
      check("rst_valid",  32'(a_rsp_valid), 32'd0);
      check("rst_rdata",  a_rsp_rdata,      32'd0);
      check("rst_err",    32'(a_rsp_err),   32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst_a", 32'(a_ready), 32'd1);
    check("ready_after_rst_b", 32'(b_ready), 32'd1);

    for (int i = 0; i < tbl.size(); i++) access(tbl[i], 1);

    // Back-to-back: req_valid held high across four word accesses.
    op_we[0] = 1; op_addr[0] = 32'h20; op_wd[0] = 32'hCAFEF00D;
    op_we[1] = 0; op_addr[1] = 32'h20; op_wd[1] = 32'h0;
    op_we[2] = 1; op_addr[2] = 32'h24; op_wd[2] = 32'h0BADC0DE;
    op_we[3] = 0; op_addr[3] = 32'h20; op_wd[3] = 32'h0;
    idx = 0; pulses = 0; cyc = 0;
    drive(op_we[0], op_addr[0], W, 0, op_wd[0]);
    req_valid = 1'b1;
    while ((idx < 4 || exp_q.size() > 0) && cyc < 60) begin
      if (rsp_valid) begin
        pulses++;
        check("b2b_ready_in_resp", 32'(ready), 32'd0);
        if (exp_q.size() == 0) check("b2b_spurious_rsp", 32'(rsp_valid), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("b2b_rdata", rsp_rdata, e);
          check("b2b_err", 32'(rsp_err), 32'd0);
        end
      end
      acc_now = req_valid && ready;
      @(posedge clk); #1; cyc++;
      if (acc_now) begin
        if (op_we[idx]) begin
          for (int k = 0; k < 4; k++) ref_b[op_addr[idx] + 32'(k)] = op_wd[idx][8*k +: 8];
          exp_q.push_back(32'h0);
        end else begin
          exp_q.push_back({ref_b[op_addr[idx] + 3], ref_b[op_addr[idx] + 2],
                           ref_b[op_addr[idx] + 1], ref_b[op_addr[idx]]});
        end
        idx++;
        if (idx < 4) drive(op_we[idx], op_addr[idx], W, 0, op_wd[idx]);
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b_issued", 32'(idx), 32'd4);
    check("b2b_pulses", 32'(pulses), 32'd4);

    // RD_LAT=3 instance.
    sel = 1'b1;
    @(posedge clk); #1;
    access(mk("b_sw_10", 1, 32'h10, W, 0, 32'h80ADBEEF, 32'h0, 0), 1);

    drive(0, 32'h12, H, 0, 32'h0);
    req_valid = 1'b1;
    check("b_lh_ready_pre", 32'(ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("b_lh_ready_low", 32'(ready), 32'd0);
      check("b_lh_valid", 32'(rsp_valid), 32'(i == 2));
      if (i == 2) begin
        check("b_lh_rdata", rsp_rdata, 32'hFFFF80AD);
        check("b_lh_err", 32'(rsp_err), 32'd0);
      end
      @(posedge clk); #1;
    end
    check("b_lh_ready_back", 32'(ready), 32'd1);
    check("b_lh_valid_drop", 32'(rsp_valid), 32'd0);

    // Reset one cycle into a read: the response must never appear.
    drive(0, 32'h12, H, 0, 32'h0);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    pulses = rsp_valid ? 1 : 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) begin
      if (rsp_valid) pulses++;
      @(posedge clk); #1;
    end
    check("b_rst_cancel_pulses", 32'(pulses), 32'd0);
    check("b_rst_ready", 32'(ready), 32'd1);
    access(mk("b_lw_after_rst", 0, 32'h10, W, 0, 32'h0, 32'h80ADBEEF, 0), 3);
    access(mk("b_lbu_12", 0, 32'h12, B, 1, 32'h0, 32'h000000AD, 0), 3);
    access(mk("b_lw_err", 0, 32'h11, W, 0, 32'h0, 32'h0, 1), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, vectors %0d", n_vec);
    $fatal(1);
  end

endmodule
